// File: rtl/cut_bist_pkg.sv
// Shared types and constants for the CUT BIST controller.
// The LFSR taps table exists only when CUT_BIST_LFSR_EN is defined.
package cut_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;

`ifdef CUT_BIST_LFSR_EN
  // Maximal-length tap masks (bit i set = state bit i feeds the XOR).
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    logic [15:0] taps;
    case (width)
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction
`endif

endpackage

// File: rtl/cut_bist_misr.sv
// Multiple-input signature register: clear has priority over capture.
module cut_bist_misr
  import cut_bist_pkg::*;
#(
  parameter int unsigned SIG_W  = 16,
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(data);
    end
  end

endmodule

// File: rtl/cut_bist_ctrl.sv
// BIST sequencer: drives CUT patterns (counter, or LFSR with CUT_BIST_LFSR_EN),
// compacts responses in a MISR and checks the signature against a golden value.
module cut_bist_ctrl
  import cut_bist_pkg::*;
#(
  parameter int unsigned IN_W   = 5,
  parameter int unsigned OUT_W  = 2,
  parameter int unsigned SIG_W  = 16,
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] GOLDEN = 16'h0000
`ifdef CUT_BIST_LFSR_EN
  , parameter logic [15:0] GOLDEN_LFSR = 16'h0000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  state_t          state, state_d;
  logic [IN_W-1:0] pat, pat_d;
  logic [3:0]      cnt, cnt_d;
  logic            pass_q, pass_d;
  logic            misr_clr, misr_en;
  logic [IN_W-1:0] first_pat, next_pat;
  logic            last_pat;
  logic [SIG_W-1:0] golden_sel;

`ifdef CUT_BIST_LFSR_EN
  localparam logic [15:0] TAPS = lfsr_taps(IN_W);

  logic mode_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (misr_clr) begin
      mode_q <= mode;
    end
  end

  // With seed 1 the LFSR's last state is 100..0, whose successor is the seed.
  always_comb begin
    first_pat  = mode ? IN_W'(1) : '0;
    next_pat   = mode_q ? {pat[IN_W-2:0], ^(pat & TAPS[IN_W-1:0])} : pat + IN_W'(1);
    last_pat   = mode_q ? (pat == {1'b1, {(IN_W-1){1'b0}}}) : (pat == '1);
    golden_sel = mode_q ? SIG_W'(GOLDEN_LFSR) : SIG_W'(GOLDEN);
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    first_pat  = '0;
    next_pat   = pat + IN_W'(1);
    last_pat   = (pat == '1);
    golden_sel = SIG_W'(GOLDEN);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pat    <= '0;
      cnt    <= '0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_d;
      pat    <= pat_d;
      cnt    <= cnt_d;
      pass_q <= pass_d;
    end
  end

  always_comb begin
    state_d  = state;
    pat_d    = pat;
    cnt_d    = cnt;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d  = APPLY;
          pat_d    = first_pat;
          cnt_d    = '0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
        end
      end
      APPLY: begin
        if (cnt == 4'(SETTLE)) begin
          misr_en = 1'b1;
          cnt_d   = '0;
          if (last_pat) begin
            state_d = CHECK;
          end else begin
            pat_d = next_pat;
          end
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      CHECK: begin
        pass_d  = (signature == golden_sel);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  cut_bist_misr #(
    .SIG_W (SIG_W),
    .DATA_W(OUT_W)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (misr_clr),
    .en   (misr_en),
    .data (cut_out),
    .sig  (signature)
  );

  assign cut_in = (state == APPLY) ? pat : '0;
  assign busy   = (state == APPLY) || (state == CHECK);
  assign done   = (state == DONE);
  assign pass   = pass_q;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// Directed bench for cut_bist_ctrl driving a c17 model; LFSR checks need CUT_BIST_LFSR_EN.
module tb_cut_bist_ctrl;

  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[0] & v[2]);
    n11 = ~(v[2] & v[3]);
    n16 = ~(v[1] & n11);
    n19 = ~(n11 & v[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'h0, d};
  endfunction

  // x^5+x^3+1: feedback from bits 4 and 2
  function automatic logic [4:0] lfsr_next(input logic [4:0] p);
    return {p[3:0], p[4] ^ p[2]};
  endfunction

  function automatic logic [15:0] model_sig(input logic lf, input logic stk);
    logic [15:0] s;
    logic [4:0]  p;
    logic [1:0]  o;
    s = 16'h0000;
    p = lf ? 5'd1 : 5'd0;
    for (int i = 0; i < (lf ? 31 : 32); i++) begin
      o = c17(p);
      if (stk) o[0] = 1'b0;
      s = misr_step(s, o);
      p = lf ? lfsr_next(p) : p + 5'd1;
    end
    return s;
  endfunction

  localparam logic [15:0] G_CNT   = model_sig(1'b0, 1'b0);
  localparam logic [15:0] G_STUCK = model_sig(1'b0, 1'b1);
  localparam logic [15:0] G_LFSR  = model_sig(1'b1, 1'b0);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_c = 1'b0, mode_c = 1'b0, start_l = 1'b0, mode_l = 1'b0;
  logic stuck = 1'b0, sel = 1'b0;
  logic [4:0]  cut_in_c, cut_in_l;
  logic [1:0]  cut_out_c;
  logic        busy_c, done_c, pass_c, busy_l, done_l, pass_l;
  logic [15:0] sig_c, sig_l;

  logic [4:0]  obs_in;
  logic        obs_busy, obs_done, obs_pass;
  logic [15:0] obs_sig;

  logic [4:0]  pat_log [32];
  logic [31:0] seen;

  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  assign cut_out_c = c17(cut_in_c) & {1'b1, ~stuck};

  cut_bist_ctrl #(
    .IN_W  (5),
    .OUT_W (2),
    .SIG_W (16),
    .SETTLE(1),
    .GOLDEN(G_CNT)
  ) dut_c (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .mode     (mode_c),
    .cut_in   (cut_in_c),
    .cut_out  (cut_out_c),
    .busy     (busy_c),
    .done     (done_c),
    .pass     (pass_c),
    .signature(sig_c)
  );

`ifdef CUT_BIST_LFSR_EN
  logic [1:0] cut_out_l;
  assign cut_out_l = c17(cut_in_l) & {1'b1, ~stuck};

  cut_bist_ctrl #(
    .IN_W       (5),
    .OUT_W      (2),
    .SIG_W      (16),
    .SETTLE     (0),
    .GOLDEN     (16'h0000),
    .GOLDEN_LFSR(G_LFSR)
  ) dut_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_l),
    .mode     (mode_l),
    .cut_in   (cut_in_l),
    .cut_out  (cut_out_l),
    .busy     (busy_l),
    .done     (done_l),
    .pass     (pass_l),
    .signature(sig_l)
  );
`else
  assign cut_in_l = '0;
  assign busy_l   = 1'b0;
  assign done_l   = 1'b0;
  assign pass_l   = 1'b0;
  assign sig_l    = '0;
`endif

  assign obs_in   = sel ? cut_in_l : cut_in_c;
  assign obs_busy = sel ? busy_l : busy_c;
  assign obs_done = sel ? done_l : done_c;
  assign obs_pass = sel ? pass_l : pass_c;
  assign obs_sig  = sel ? sig_l : sig_c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One run; t counts edges after the accepting edge e0. mid>=0 pulses start mid-run.
  task automatic run(input logic lf, input logic md, input int mid,
                     output int done_t, output int seq_bad);
    int n, hold;
    logic [4:0] p;
    n       = lf ? 31 : 32;
    hold    = lf ? 1 : 2;
    done_t  = -1;
    seq_bad = 0;
    seen    = '0;
    p       = lf ? 5'd1 : 5'd0;
    sel     = lf;
    @(negedge clk);
    if (lf) begin start_l = 1'b1; mode_l = md; end
    else begin start_c = 1'b1; mode_c = md; end
    @(posedge clk); #1;
    start_c = 1'b0;
    start_l = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (t < n * hold) begin
        if (obs_in !== p || obs_busy !== 1'b1) seq_bad++;
        if (t % hold == 0) pat_log[t / hold] = obs_in;
        seen[obs_in] = 1'b1;
        if (t % hold == hold - 1) p = lf ? lfsr_next(p) : p + 5'd1;
      end
      if (obs_done === 1'b1) begin
        done_t = t;
        break;
      end
      if (t == mid) begin
        if (lf) start_l = 1'b1;
        else start_c = 1'b1;
      end
      @(posedge clk); #1;
      start_c = 1'b0;
      start_l = 1'b0;
    end
  endtask

  initial begin
    int dt, sb, w;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cut_in", cut_in_c, 0);
    check("rst_busy", busy_c, 0);
    check("rst_done", done_c, 0);
    check("rst_pass", pass_c, 0);
    check("rst_sig", sig_c, 0);
    rst_n = 1'b1;

    run(1'b0, 1'b0, -1, dt, sb);
    check("cnt_done_time", dt, 65);
    check("cnt_seq", sb, 0);
    check("cnt_last_pat", pat_log[31], 31);
    check("cnt_sig", sig_c, G_CNT);
    check("cnt_pass", pass_c, 1);
    check("cnt_busy_end", busy_c, 0);
    check("cnt_cut_in_end", cut_in_c, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_sticky", done_c, 1);
    check("sig_hold", sig_c, G_CNT);

    stuck = 1'b1;
    run(1'b0, 1'b0, -1, dt, sb);
    stuck = 1'b0;
    check("stuck_done_time", dt, 65);
    check("stuck_sig", sig_c, G_STUCK);
    check("stuck_sig_differs", (sig_c != G_CNT), 1);
    check("stuck_pass", pass_c, 0);

    run(1'b0, 1'b0, 30, dt, sb);
    check("midstart_done_time", dt, 65);
    check("midstart_seq", sb, 0);
    check("midstart_sig", sig_c, G_CNT);

    sel = 1'b0;
    @(negedge clk);
    start_c = 1'b1;
    mode_c  = 1'b0;
    @(posedge clk); #1;
    start_c = 1'b0;
    w = 0;
    while (cut_in_c !== 5'd10 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("rst_reach_p10", w, 20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_cut_in", cut_in_c, 0);
    check("abort_busy", busy_c, 0);
    check("abort_done", done_c, 0);
    check("abort_pass", pass_c, 0);
    check("abort_sig", sig_c, 0);
    rst_n = 1'b1;
    run(1'b0, 1'b0, -1, dt, sb);
    check("rerun_done_time", dt, 65);
    check("rerun_seq", sb, 0);
    check("rerun_sig", sig_c, G_CNT);
    check("rerun_pass", pass_c, 1);

`ifdef CUT_BIST_LFSR_EN
    run(1'b1, 1'b1, -1, dt, sb);
    check("lfsr_done_time", dt, 32);
    check("lfsr_seq", sb, 0);
    check("lfsr_p0", pat_log[0], 1);
    check("lfsr_p1", pat_log[1], 2);
    check("lfsr_p2", pat_log[2], 4);
    check("lfsr_p3", pat_log[3], 9);
    check("lfsr_last", pat_log[30], 16);
    check("lfsr_distinct", $countones(seen), 31);
    check("lfsr_no_zero", seen[0], 0);
    check("lfsr_sig", sig_l, G_LFSR);
    check("lfsr_pass", pass_l, 1);
    stuck = 1'b1;
    run(1'b1, 1'b1, -1, dt, sb);
    stuck = 1'b0;
    check("lfsr_stuck_pass", pass_l, 0);
`else
    run(1'b0, 1'b1, -1, dt, sb);
    check("nolfsr_done_time", dt, 65);
    check("nolfsr_seq", sb, 0);
    check("nolfsr_last_pat", pat_log[31], 31);
    check("nolfsr_sig", sig_c, G_CNT);
    check("nolfsr_pass", pass_c, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cut_bist_ctrl.md
# cut_bist_ctrl

Parametrised built-in self-test controller for small combinational circuits-under-test (CUT) such as the c17 benchmark. It drives `IN_W` CUT inputs with an exhaustive counter sequence or a pseudo-random LFSR sequence and waits a programmable settle time per pattern. It compacts the `OUT_W` CUT outputs into a `SIG_W`-bit MISR signature and compares that signature against a golden value. It replaces hand-written exhaustive vector benches with a clocked, self-checking on-chip sequencer.

## Interface
Parameters:
- `IN_W`, 5: CUT input count; legal range 3..16.
- `OUT_W`, 2: CUT output count; must satisfy `OUT_W <= SIG_W`.
- `SIG_W`, 16: MISR width; only 16 is supported, because the package constant is fixed.
- `SETTLE`, 1: cycles to wait after applying a pattern before capture; range 0..15.
- `GOLDEN`, 16'h0000: expected signature in counter mode.
- `GOLDEN_LFSR`, 16'h0000: expected signature in LFSR mode.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  single-cycle run request.
- `mode`  in  1  0 = exhaustive counter, 1 = LFSR; sampled together with `start`.
- `cut_in`  out  `IN_W`  pattern driven to the CUT.
- `cut_out`  in  `OUT_W`  CUT response.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; sticky until the next accepted `start` or reset.
- `pass`  out  1  signature matched the golden value; valid while `done=1`.
- `signature`  out  `SIG_W`  current MISR contents.

## Operation
- FSM states and transitions:
  - IDLE to APPLY on `start`.
  - APPLY holds the pattern for `SETTLE+1` cycles, then either advances to the next pattern or moves to CHECK after the last one.
  - CHECK goes to DONE after one cycle.
  - DONE goes to APPLY on `start`.
- `start` is accepted only in IDLE or DONE and is ignored while `busy=1`.
- Accepting `start`:
  - latches `mode`, clears MISR to 0, clears `done` and `pass`, and sets `busy`;
  - loads the first pattern: 0 in counter mode, `{IN_W-1'b0,1'b1}` in LFSR mode.
- Counter mode applies patterns 0 .. 2^IN_W−1 in ascending order, N = 2^IN_W. The last pattern is detected by count value, not by wrap.
- LFSR mode:
  - Fibonacci LFSR, shifting left, feedback bit = XOR of tap bits taken from the package taps table.
  - Applies N = 2^IN_W−1 nonzero patterns; the all-zero pattern is never applied.
- MISR capture happens on the last cycle of each pattern hold.
  - Update rule: `sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zext(cut_out)`.
  - `POLY` = 16'h1021.
- CHECK registers `pass = (signature == golden for latched mode)`, then DONE sets `done=1` and `busy=0`.
- Reset values: `cut_in`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0, FSM in IDLE.
- Reset asserted mid-run aborts the run immediately to the reset values; no partial result is reported.
- In IDLE and DONE, `cut_in` is driven to 0 and `signature` holds its last value.

## Timing
- Take `start` as sampled at edge e0:
  - `cut_in`=P0 and `busy`=1 after e0.
  - Pattern Pk is driven after edge e0+k·(SETTLE+1).
  - Pk is captured at edge e0+(k+1)·(SETTLE+1).
- `done`, `pass` and `busy=0` appear after edge e0+N·(SETTLE+1)+1.
- Example: counter mode with IN_W=5 and SETTLE=1 gives 32 patterns and `done` after edge e0+65.
- `cut_out` must be stable SETTLE+1 cycles after `cut_in` changes. A combinational CUT with SETTLE=0 is legal.
- A `start` on the same cycle that DONE is entered is not accepted; it is only accepted in the following cycle.

## Configuration
- `CUT_BIST_LFSR_EN` defined: the LFSR generator, the taps table and `GOLDEN_LFSR` are compiled in, and `mode` selects the generator.
- Macro undefined:
  - only the counter generator exists;
  - `mode` is ignored, and every run uses counter mode with `GOLDEN`;
  - the LFSR logic must be absent from synthesis.

## Structure
- Package `cut_bist_pkg` holds:
  - FSM state enum (IDLE, APPLY, CHECK, DONE);
  - `MISR_POLY`=16'h1021;
  - function `lfsr_taps(width)`, a table for widths 3..16; e.g. width 5 returns taps at bits 4 and 2, i.e. x^5+x^3+1.
- One sub-module, `cut_bist_misr`: the SIG_W-bit MISR with clear and capture-enable inputs.
- The pattern generator, settle counter and FSM stay in the top module.

## Test plan
- Counter mode, IN_W=5, SETTLE=1, c17 model as the CUT:
  - `cut_in` steps 0..31, each value held 2 cycles;
  - `done` rises after 65 edges;
  - `signature` equals the bench's MISR model;
  - with `GOLDEN` set to that value, `pass`=1.
- Same run with `cut_out[0]` forced stuck-at-0: `signature` differs from the model and `pass`=0.
- LFSR mode (macro defined), IN_W=5, SETTLE=0, seed 1:
  - 31 distinct nonzero patterns;
  - the sequence matches the x^5+x^3+1 model;
  - `done` after 32 edges;
  - `pass` follows `GOLDEN_LFSR`.
- `start` pulsed mid-run: ignored, and the pattern sequence and completion time are unchanged.
- `rst_n`=0 at pattern 10: all outputs return to reset values the next cycle; a fresh `start` reruns from P0 with an identical signature.
- Macro undefined, `start` with `mode`=1: the counter sequence runs, 32 patterns, compared against `GOLDEN`.
